mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 42 ++++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit_load_extend.sv | 32 +++
 rtl/mem_access_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store memory access unit.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
package mem_access_pkg;

    // funct3 encodings for loads
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // funct3 encodings for stores
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the size/sign code and the address offset form a legal access.
    // A store is assumed whenever store is set, even if a load is also flagged.
    function automatic logic access_legal(input logic store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        if (store) begin
            if (f3 > SW) ok = 1'b0;
        end else if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
            ok = 1'b0;
        end
        if (f3[1:0] == 2'b01 && off[0]) ok = 1'b0;
        if (f3[1:0] == 2'b10 && off != 2'b00) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit: one request, answered by mem_ready.
// Latency: memory accepts and returns read data in the cycle mem_ready is high.
// Backpressure: mem_req stays asserted until the memory raises mem_ready.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a read word and extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = word >> {offset, 3'b000};
    assign half_shift = word >> {offset[1], 4'b0000};

    // Lane select followed by sign or zero extension
    always_comb begin
        result = '0;
        case (funct3)
            LB:      result = {{24{byte_shift[7]}}, byte_shift[7:0]};
            LH:      result = {{16{half_shift[15]}}, half_shift[15:0]};
            LW:      result = word;
            LBU:     result = {24'b0, byte_shift[7:0]};
            LHU:     result = {16'b0, half_shift[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: checks legality, issues one memory request, returns extended load data.
// Latency: 2 edges plus memory wait cycles; done pulses for one cycle in DONE.
// Backpressure: stall holds the pipeline; the request waits on mem_ready up to TIMEOUT_CYCLES.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_err,
    mem_access_unit_if.master bus
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);

    state_t          state, state_nxt;
    logic            access, legal, timeout_hit;
    logic [31:0]     addr_q, wdata_q, rword_q, ext_res;
    logic [2:0]      f3_q;
    logic            we_q, err_q;
    logic [CNT_W-1:0] wait_cnt;

    assign access      = is_load | is_store;
    assign legal       = access && access_legal(is_store, funct3, addr[1:0]);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (legal) state_nxt = REQ;
            REQ:     if (bus.mem_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Access latches, wait counter, read-word capture and timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            rword_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else if (state == IDLE && legal) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            f3_q     <= funct3;
            we_q     <= is_store;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else if (state == REQ) begin
            if (bus.mem_ready) begin
                rword_q <= bus.mem_rdata;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    // Store byte enables and lane replication, driven from the latched access only
    always_comb begin
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                bus.mem_wdata = {4{wdata_q[7:0]}};
                if (we_q) bus.mem_be = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                bus.mem_wdata = {2{wdata_q[15:0]}};
                if (we_q) bus.mem_be = 4'b0011 << addr_q[1:0];
            end
            default: begin
                if (we_q) bus.mem_be = 4'b1111;
            end
        endcase
    end

    load_extend u_load_extend (
        .word   (rword_q),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .result (ext_res)
    );

    assign bus.mem_req  = (state == REQ);
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = {addr_q[31:2], 2'b00};

    assign stall        = ((state == IDLE) && legal) || (state == REQ);
    assign misalign_err = (state == IDLE) && access && !legal;
    assign done         = (state == DONE);
    assign bus_err      = (state == DONE) && err_q;
    assign rdata        = ((state == DONE) && !we_q && !err_q) ? ext_res : '0;

endmodule
